// File: rtl/multicycle_control_if.sv
// Bundle of the controller's handshake inputs and datapath control outputs.
// The controller connects through the slave modport; whoever drives the
// instruction stream and memory handshake uses the master modport.
interface multicycle_control_if;
    logic        Run;
    logic [6:0]  Opcode;
    logic        Zero;
    logic        MemReady;
    logic [1:0]  ALUOp;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic        MemRead;
    logic        MemWrite;
    logic        IRWrite;
    logic        PCWrite;
    logic        PCSrc;
    logic        RegWrite;
    logic        MemToReg;
    logic        Busy;
    logic        Fault;
    logic [15:0] InstrCount;

    modport master (
        output Run, Opcode, Zero, MemReady,
        input  ALUOp, ALUSrcA, ALUSrcB, MemRead, MemWrite, IRWrite, PCWrite,
               PCSrc, RegWrite, MemToReg, Busy, Fault, InstrCount
    );

    modport slave (
        input  Run, Opcode, Zero, MemReady,
        output ALUOp, ALUSrcA, ALUSrcB, MemRead, MemWrite, IRWrite, PCWrite,
               PCSrc, RegWrite, MemToReg, Busy, Fault, InstrCount
    );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle control FSM for a small RISC-style datapath. Sequences fetch,
// decode, execute, memory and write-back, counts completed instructions and
// falls into a sticky FAULT state on an unknown opcode or a memory timeout.
module multicycle_control #(
    parameter int TIMEOUT = 15
) (
    input logic                clk,
    input logic                reset,
    multicycle_control_if.slave bus
);

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LW = 7'b0000011;
    localparam logic [6:0] OP_SW = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    // Wait-counter value seen on the last permitted not-ready cycle.
    localparam logic [3:0] WAIT_LAST = 4'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC_R,
        EXEC_I,
        EXEC_BR,
        ADDR,
        MEM_RD,
        MEM_WR,
        WB_ALU,
        WB_MEM,
        FAULT
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [3:0]  wait_count;
    logic [15:0] instr_count;
    logic        complete;
    logic        waiting;
    logic        timed_out;

    assign timed_out      = (wait_count == WAIT_LAST);
    assign bus.InstrCount = instr_count;

    // Next-state selection and Moore output decode; IRWrite/PCWrite and the
    // completion pulse additionally look at MemReady or Zero.
    always_comb begin
        next_state   = state;
        complete     = 1'b0;
        waiting      = 1'b0;
        bus.ALUOp    = 2'b00;
        bus.ALUSrcA  = 1'b0;
        bus.ALUSrcB  = 2'b00;
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
        bus.IRWrite  = 1'b0;
        bus.PCWrite  = 1'b0;
        bus.PCSrc    = 1'b0;
        bus.RegWrite = 1'b0;
        bus.MemToReg = 1'b0;
        bus.Busy     = (state != IDLE) && (state != FAULT);
        bus.Fault    = (state == FAULT);

        case (state)
            IDLE: begin
                if (bus.Run) next_state = FETCH;
            end
            FETCH: begin
                waiting      = 1'b1;
                bus.MemRead  = 1'b1;
                bus.ALUSrcB  = 2'b01;
                bus.IRWrite  = bus.MemReady;
                bus.PCWrite  = bus.MemReady;
                if (bus.MemReady)   next_state = DECODE;
                else if (timed_out) next_state = FAULT;
            end
            DECODE: begin
                case (bus.Opcode)
                    OP_R:         next_state = EXEC_R;
                    OP_I:         next_state = EXEC_I;
                    OP_LW, OP_SW: next_state = ADDR;
                    OP_BR:        next_state = EXEC_BR;
                    default:      next_state = FAULT;
                endcase
            end
            EXEC_R: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b00;
                bus.ALUOp   = 2'b10;
                next_state  = WB_ALU;
            end
            EXEC_I: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                bus.ALUOp   = 2'b10;
                next_state  = WB_ALU;
            end
            EXEC_BR: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b00;
                bus.ALUOp   = 2'b01;
                bus.PCSrc   = 1'b1;
                bus.PCWrite = bus.Zero;
                complete    = 1'b1;
            end
            ADDR: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                bus.ALUOp   = 2'b00;
                if (bus.Opcode == OP_LW)      next_state = MEM_RD;
                else if (bus.Opcode == OP_SW) next_state = MEM_WR;
                else                          next_state = FAULT;
            end
            MEM_RD: begin
                waiting     = 1'b1;
                bus.MemRead = 1'b1;
                if (bus.MemReady)   next_state = WB_MEM;
                else if (timed_out) next_state = FAULT;
            end
            MEM_WR: begin
                waiting      = 1'b1;
                bus.MemWrite = 1'b1;
                if (bus.MemReady)   complete   = 1'b1;
                else if (timed_out) next_state = FAULT;
            end
            WB_ALU: begin
                bus.RegWrite = 1'b1;
                bus.MemToReg = 1'b0;
                complete     = 1'b1;
            end
            WB_MEM: begin
                bus.RegWrite = 1'b1;
                bus.MemToReg = 1'b1;
                complete     = 1'b1;
            end
            FAULT: begin
                next_state = FAULT;
            end
            default: begin
                next_state = FAULT;
            end
        endcase

        if (complete) next_state = bus.Run ? FETCH : IDLE;
    end

    // State register; reset wins over everything, including FAULT.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Memory wait counter: counts not-ready cycles in a waiting state and is
    // zero everywhere else, so it always starts from zero on entry.
    always_ff @(posedge clk) begin
        if (reset)                         wait_count <= 4'd0;
        else if (waiting && !bus.MemReady) wait_count <= wait_count + 4'd1;
        else                               wait_count <= 4'd0;
    end

    // Completed-instruction counter, wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (reset)         instr_count <= 16'd0;
        else if (complete) instr_count <= instr_count + 16'd1;
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control. A reference model expands each instruction
// into its expected per-cycle control words from the instruction class
// rules, then the plan is replayed against the DUT cycle by cycle.
module tb_multicycle_control;

    localparam int TIMEOUT = 15;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LW = 7'b0000011;
    localparam logic [6:0] OP_SW = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    logic clk = 1'b0;
    logic reset = 1'b1;

    // Free-running clock, 10 ns period.
    always #5 clk = ~clk;

    multicycle_control_if bus();

    multicycle_control #(.TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string       tag;
        logic [13:0] ctrl;
        logic [15:0] cnt;
        bit          run;
        bit          rdy;
        bit          zero;
        logic [6:0]  op;
    } step_t;

    step_t       plan[$];
    logic [15:0] model_count = 16'd0;
    int          errors = 0;
    int          checks = 0;

    function automatic logic [13:0] cw(logic [1:0] aluop, bit srca, logic [1:0] srcb,
                                       bit mr, bit mw, bit ir, bit pcw, bit pcs,
                                       bit rw, bit m2r, bit busy, bit fault);
        return {aluop, srca, srcb, mr, mw, ir, pcw, pcs, rw, m2r, busy, fault};
    endfunction

    function automatic logic [13:0] observedCtrl();
        return {bus.ALUOp, bus.ALUSrcA, bus.ALUSrcB, bus.MemRead, bus.MemWrite,
                bus.IRWrite, bus.PCWrite, bus.PCSrc, bus.RegWrite, bus.MemToReg,
                bus.Busy, bus.Fault};
    endfunction

    function automatic void push(string tag, logic [13:0] ctrl, bit run, bit rdy,
                                 bit zero, logic [6:0] op);
        step_t s;
        s.tag  = tag;
        s.ctrl = ctrl;
        s.cnt  = model_count;
        s.run  = run;
        s.rdy  = rdy;
        s.zero = zero;
        s.op   = op;
        plan.push_back(s);
    endfunction

    function automatic bit anyBit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic void addIdle(bit run);
        push("idle", 14'd0, run, anyBit(), anyBit(), 7'd0);
    endfunction

    function automatic void addFault(logic [6:0] op);
        for (int i = 0; i < 3; i++)
            push("fault", cw(2'b00, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1), 1'b1, anyBit(), anyBit(), op);
    endfunction

    // Expands one instruction into its cycles. fwait/mwait are the number of
    // not-ready memory cycles before MemReady; run_next is the Run level seen
    // from the third cycle on, which decides FETCH or IDLE after completion.
    function automatic void addInstr(string name, logic [6:0] op, bit z,
                                     int fwait, int mwait, bit run_next);
        int k = 0;
        logic [13:0] busy_only = cw(2'b00, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < fwait && i < TIMEOUT; i++) begin
            push({name, "-fetchwait"}, cw(2'b00, 0, 2'b01, 1, 0, 0, 0, 0, 0, 0, 1, 0),
                 (k < 2) || run_next, 1'b0, z, op);
            k++;
        end
        if (fwait >= TIMEOUT) begin
            addFault(op);
            return;
        end
        push({name, "-fetch"}, cw(2'b00, 0, 2'b01, 1, 0, 1, 1, 0, 0, 0, 1, 0),
             (k < 2) || run_next, 1'b1, z, op);
        k++;
        push({name, "-decode"}, busy_only, (k < 2) || run_next, anyBit(), z, op);
        k++;
        if (op == OP_R || op == OP_I) begin
            push({name, "-exec"}, cw(2'b10, 1, (op == OP_R) ? 2'b00 : 2'b10, 0, 0, 0, 0, 0, 0, 0, 1, 0),
                 run_next, anyBit(), z, op);
            push({name, "-wb"}, cw(2'b00, 0, 2'b00, 0, 0, 0, 0, 0, 1, 0, 1, 0),
                 run_next, anyBit(), z, op);
            model_count++;
        end else if (op == OP_BR) begin
            push({name, "-branch"}, cw(2'b01, 1, 2'b00, 0, 0, 0, z, 1, 0, 0, 1, 0),
                 run_next, anyBit(), z, op);
            model_count++;
        end else if (op == OP_LW || op == OP_SW) begin
            push({name, "-addr"}, cw(2'b00, 1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 1, 0),
                 run_next, anyBit(), z, op);
            for (int i = 0; i < mwait && i < TIMEOUT; i++)
                push({name, "-memwait"}, cw(2'b00, 0, 2'b00, op == OP_LW, op == OP_SW, 0, 0, 0, 0, 0, 1, 0),
                     run_next, 1'b0, z, op);
            if (mwait >= TIMEOUT) begin
                addFault(op);
                return;
            end
            push({name, "-mem"}, cw(2'b00, 0, 2'b00, op == OP_LW, op == OP_SW, 0, 0, 0, 0, 0, 1, 0),
                 run_next, 1'b1, z, op);
            if (op == OP_LW)
                push({name, "-wbmem"}, cw(2'b00, 0, 2'b00, 0, 0, 0, 0, 0, 1, 1, 1, 0),
                     run_next, anyBit(), z, op);
            model_count++;
        end else begin
            addFault(op);
        end
    endfunction

    task automatic checkOutput(string tag, logic [15:0] observed, logic [15:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Replays up to n planned cycles: drive at the falling edge, check 1 ns later.
    task automatic applyStimulus(int n);
        int done = 0;
        while (plan.size() > 0 && done < n) begin
            step_t s;
            s = plan.pop_front();
            @(negedge clk);
            bus.Run      = s.run;
            bus.MemReady = s.rdy;
            bus.Zero     = s.zero;
            bus.Opcode   = s.op;
            #1;
            checkOutput({s.tag, "-ctrl"}, {2'b00, observedCtrl()}, {2'b00, s.ctrl});
            checkOutput({s.tag, "-count"}, bus.InstrCount, s.cnt);
            done++;
        end
    endtask

    // Holds reset for one edge with busy-looking inputs, then checks idle state.
    task automatic doReset(string tag);
        plan.delete();
        @(negedge clk);
        reset        = 1'b1;
        bus.Run      = 1'b1;
        bus.MemReady = 1'b1;
        bus.Zero     = 1'b1;
        bus.Opcode   = OP_R;
        @(negedge clk);
        #1;
        model_count = 16'd0;
        checkOutput({tag, "-ctrl"}, {2'b00, observedCtrl()}, 16'd0);
        checkOutput({tag, "-count"}, bus.InstrCount, 16'd0);
        reset   = 1'b0;
        bus.Run = 1'b0;
    endtask

    // Hard stop in case the sequence ever stalls.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: observed=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios followed by a randomized instruction stream.
    initial begin
        logic [6:0] ops [5];
        logic [6:0] bad;
        ops[0] = OP_R; ops[1] = OP_I; ops[2] = OP_LW; ops[3] = OP_SW; ops[4] = OP_BR;

        bus.Run = 1'b0; bus.MemReady = 1'b0; bus.Zero = 1'b0; bus.Opcode = 7'd0;
        doReset("reset-initial");

        addIdle(1); addInstr("r", OP_R, 0, 0, 0, 0); addIdle(0);
        applyStimulus(1000);

        addIdle(1); addInstr("lw-wait3", OP_LW, 0, 0, 3, 0); addIdle(0);
        applyStimulus(1000);

        addIdle(1);
        addInstr("sw", OP_SW, 0, 0, 2, 1);
        addInstr("br-taken", OP_BR, 1, 0, 0, 1);
        addInstr("br-not", OP_BR, 0, 0, 0, 1);
        addInstr("i", OP_I, 1, 0, 0, 0);
        addIdle(0);
        applyStimulus(1000);

        addIdle(1); addInstr("fetch14", OP_R, 0, 14, 0, 0); addIdle(0);
        applyStimulus(1000);

        @(negedge clk);
        force dut.instr_count = 16'hFFFF;
        #1;
        release dut.instr_count;
        model_count = 16'hFFFF;
        addIdle(1); addInstr("r-wrap", OP_R, 0, 0, 0, 0); addIdle(0);
        applyStimulus(1000);

        for (int n = 0; n < 40; n++) begin
            int fw, mw;
            bit rn;
            fw = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0;
            mw = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 6)) : 0;
            rn = (n != 39) && ($urandom_range(0, 4) != 0);
            if (n == 0) addIdle(1);
            addInstr("rand", ops[$urandom_range(0, 4)], anyBit(), fw, mw, rn);
            if (!rn) addIdle(n != 39);
        end
        applyStimulus(10000);

        addIdle(1); addInstr("lw-midreset", OP_LW, 0, 0, 5, 1);
        applyStimulus(5);
        doReset("reset-mid");

        addIdle(1); addInstr("fetch-timeout", OP_R, 0, 15, 0, 1);
        applyStimulus(1000);
        doReset("reset-fault-fetch");

        addIdle(1); addInstr("bad-7f", 7'h7F, 0, 0, 0, 1);
        applyStimulus(1000);
        doReset("reset-fault-op");

        do bad = 7'($urandom_range(0, 127));
        while (bad inside {OP_R, OP_I, OP_LW, OP_SW, OP_BR});
        addIdle(1); addInstr("bad-rand", bad, 0, 0, 0, 1);
        applyStimulus(1000);
        doReset("reset-fault-rand");

        addIdle(1); addInstr("sw-timeout", OP_SW, 0, 0, 15, 1);
        applyStimulus(1000);
        doReset("reset-fault-mem");

        addIdle(1); addInstr("lw-after", OP_LW, 1, 1, 1, 0); addIdle(0);
        applyStimulus(1000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter: TIMEOUT, default 15, memory-wait cycles allowed before fault (range 1..15).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 Run  input  1  level; 1 = execute instructions continuously, 0 = stop after the current instruction.
REQ-005 Opcode  input  7  instruction[6:0] from the external IR; valid from DECODE onward.
REQ-006 Zero  input  1  ALU zero flag.
REQ-007 MemReady  input  1  memory handshake; 1 = current read/write completes this cycle.
REQ-008 ALUOp  output  2  to the ALU control unit: 00 add, 01 sub, 10 funct-decoded.
REQ-009 ALUSrcA  output  1  0 = PC, 1 = register A.
REQ-010 ALUSrcB  output  2  00 = register B, 01 = constant 4, 10 = immediate.
REQ-011 MemRead, MemWrite, IRWrite, PCWrite, PCSrc, RegWrite, MemToReg  output  1 each  datapath strobes/selects.
REQ-012 Busy  output  1  1 in every state except IDLE and FAULT.
REQ-013 Fault  output  1  sticky; 1 in FAULT.
REQ-014 InstrCount  output  16  completed-instruction counter.

Function
REQ-015 The FSM SHALL have the states IDLE, FETCH, DECODE, EXEC_R, EXEC_I, EXEC_BR, ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM and FAULT.
REQ-016 Outputs are decoded from the registered state (Moore), except IRWrite, PCWrite and completion, which also qualify on inputs as stated below.
REQ-017 IDLE: all strobes 0; Run=1 -> FETCH.
REQ-018 FETCH: MemRead=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=0.
  - IRWrite=PCWrite=MemReady in the same cycle.
  - MemReady=1 -> DECODE; otherwise stay in FETCH.
REQ-019 DECODE: all strobes 0. Next state by Opcode:
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 0000011 or 0100011 -> ADDR
  - 1100011 -> EXEC_BR
  - any other value -> FAULT
REQ-020 EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> WB_ALU.
REQ-021 EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp=10 -> WB_ALU.
REQ-022 ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> MEM_RD when Opcode=0000011, MEM_WR when Opcode=0100011.
REQ-023 MEM_RD: MemRead=1; MemReady=1 -> WB_MEM, otherwise hold.
REQ-024 MEM_WR: MemWrite=1; MemReady=1 completes the instruction, otherwise hold.
REQ-025 WB_ALU: RegWrite=1, MemToReg=0; completes the instruction.
REQ-026 WB_MEM: RegWrite=1, MemToReg=1; completes the instruction.
REQ-027 EXEC_BR: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=1, PCWrite=Zero; completes the instruction.
REQ-028 On completion the next state SHALL be FETCH if Run=1, else IDLE; Run is sampled only in IDLE and at completion, so deasserting Run mid-instruction never aborts it.
REQ-029 InstrCount SHALL increment by 1 on the completion cycle and wrap from 0xFFFF to 0x0000.
REQ-030 Wait counter (4 bits):
  - cleared on entry to FETCH, MEM_RD and MEM_WR;
  - increments each cycle spent in those states with MemReady=0;
  - reaching TIMEOUT with MemReady=0 -> FAULT;
  - MemReady=1 in the same cycle takes priority over the timeout.
REQ-031 FAULT: all strobes 0, Fault=1; the FSM remains in FAULT until reset regardless of Run.
REQ-032 Instruction latency with MemReady always 1:
  - EXEC_BR path: 3 cycles
  - R, I and SW paths: 4 cycles
  - LW path: 5 cycles

Reset
REQ-033 When reset=1 at a rising edge, the FSM SHALL enter IDLE, InstrCount and the wait counter SHALL clear, and all outputs SHALL be 0 (ALUOp=00, ALUSrcB=00).
REQ-034 Reset SHALL override every other input in any state, including mid-instruction and FAULT.

Verification
REQ-035 Reset, then Run=1, MemReady=1, Opcode=0110011 -> state sequence FETCH, DECODE, EXEC_R, WB_ALU; ALUOp=10 in EXEC_R; RegWrite=1 for exactly one cycle; InstrCount=1 after 4 cycles.
REQ-036 Opcode=0000011 with MemReady=0 for 3 cycles in MEM_RD -> MemRead stays 1 for 4 cycles; WB_MEM asserts MemToReg=1; total latency 8 cycles.
REQ-037 Opcode=1100011: Zero=1 -> PCWrite=1 with PCSrc=1 in EXEC_BR; Zero=0 -> PCWrite=0; 3 cycles each.
REQ-038 Opcode=1111111 -> FAULT after DECODE, Fault=1, Busy=0, sticky with Run=1; reset -> IDLE with Fault=0.
REQ-039 TIMEOUT=15 with MemReady held at 0 in FETCH -> FAULT after 15 wait cycles; MemReady=1 on cycle 15 -> DECODE instead of FAULT.
REQ-040 Run dropped to 0 during EXEC_R -> instruction completes through WB_ALU, then IDLE; InstrCount preset 0xFFFF wraps to 0x0000.
